// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants, next-PC select enum and branch-target helper for pc_ras_unit
package pc_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int PC_STEP_DEF = 4;
    localparam int MAX_W       = 64;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_JMP,
        NPC_RET,
        NPC_HOLD
    } npc_sel_e;

    // Only the low ADDR_W bits are used by callers, so zero-extended inputs give the wrapped result.
    function automatic logic [MAX_W-1:0] br_target(input logic [MAX_W-1:0] pc_plus,
                                                   input logic [MAX_W-1:0] imm);
        return pc_plus + (imm << 2);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with top pointer and count; sticky flags under RAS_ERR_EN
module ras_stack
    import pc_pkg::*;
#(
    parameter int W     = ADDR_W_DEF,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] top_q, top_d;
    logic [PW:0]   cnt_q, cnt_d;

    assign top   = mem_q[top_q];
    assign cnt   = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PW+1)'(DEPTH));

    always_comb begin
        mem_d = mem_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (push && pop && !empty) begin
            mem_d[top_q] = wdata;
        end else if (push) begin
            // On a full stack the pointer wraps onto the oldest entry.
            top_d        = top_q + 1'b1;
            mem_d[top_d] = wdata;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !empty) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef RAS_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (push && !pop && full);
        unf_d = unf_q | (pop && empty);
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - program counter with next-PC mux and return-address stack; RAS_ERR_EN enables error flags and self-hold
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                RAS_DEPTH = 8,
    parameter int                PC_STEP   = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'hFFFF_FFFC)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         halt,
    input  logic                         pc_src,
    input  logic [ADDR_W-1:0]            br_imm,
    input  logic                         jump,
    input  logic [ADDR_W-1:0]            jump_tgt,
    input  logic                         push,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] ras_top;
    npc_sel_e          npc_sel;

    assign pc      = pc_q;
    assign pc_plus = pc_q + ADDR_W'(PC_STEP);
    assign br_pc   = ADDR_W'(br_target(MAX_W'(pc_plus), MAX_W'(br_imm)));

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push && !halt),
        .pop   (pop && !halt),
        .wdata (pc_plus),
        .top   (ras_top),
        .cnt   (ras_cnt),
        .full  (ras_full),
        .empty (ras_empty),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    always_comb begin
        npc_sel = NPC_SEQ;
        if (halt) begin
            npc_sel = NPC_HOLD;
        end else if (pop && !ras_empty) begin
            npc_sel = NPC_RET;
`ifdef RAS_ERR_EN
        end else if (pop && !push) begin
            npc_sel = NPC_HOLD;
`endif
        end else if (jump) begin
            npc_sel = NPC_JMP;
        end else if (pc_src) begin
            npc_sel = NPC_BR;
        end
    end

    always_comb begin
        pc_d = pc_plus;
        unique case (npc_sel)
            NPC_RET:  pc_d = ras_top;
            NPC_JMP:  pc_d = jump_tgt;
            NPC_BR:   pc_d = br_pc;
            NPC_HOLD: pc_d = pc_q;
            default:  pc_d = pc_plus;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb/tb_pc_ras_unit.sv - self-checking bench for pc_ras_unit with a queue-based reference model
module tb_pc_ras_unit;

`ifdef RAS_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam int          DEPTH  = 8;

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic        halt = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] br_imm = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_tgt = '0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] pc, pc_plus;
    logic [3:0]  ras_cnt;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_ras[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    pc_ras_unit dut (
        .clk       (clk),
        .reset     (reset),
        .halt      (halt),
        .pc_src    (pc_src),
        .br_imm    (br_imm),
        .jump      (jump),
        .jump_tgt  (jump_tgt),
        .push      (push),
        .pop       (pop),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .ras_cnt   (ras_cnt),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a return stack is a list; overflow forgets the oldest call.
    task automatic model_step();
        logic [31:0] plus, nxt;
        if (!reset) begin
            m_pc = RST_PC;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!halt) begin
            plus = m_pc + 32'd4;
            nxt  = plus;
            if (jump) nxt = jump_tgt;
            else if (pc_src) nxt = plus + (br_imm * 32'd4);
            if (pop && m_ras.size() > 0) begin
                nxt = m_ras[$];
                if (push) m_ras[$] = plus;
                else void'(m_ras.pop_back());
            end else begin
                if (pop) begin
                    m_unf = 1'b1;
                    if (ERR && !push) nxt = m_pc;
                end
                if (push) begin
                    m_ras.push_back(plus);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end
            end
            m_pc = nxt;
        end
    endtask

    initial forever begin
        @(negedge clk or negedge reset);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        chk("cmp_pc", pc, m_pc);
        chk("cmp_pc_plus", pc_plus, m_pc + 32'd4);
        chk("cmp_ras_cnt", 32'(ras_cnt), 32'(m_ras.size()));
        chk("cmp_ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        chk("cmp_ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
        chk("cmp_ras_ovf", 32'(ras_ovf), 32'(ERR && m_ovf));
        chk("cmp_ras_unf", 32'(ras_unf), 32'(ERR && m_unf));
    end

    task automatic drive(input logic pu, input logic po, input logic ju, input logic [31:0] jt,
                         input logic bs, input logic [31:0] imm, input logic h);
        push = pu; pop = po; jump = ju; jump_tgt = jt; pc_src = bs; br_imm = imm; halt = h;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        #22;
        chk("rst_pc", pc, RST_PC);
        chk("rst_cnt", 32'(ras_cnt), 32'd0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;

        idle(); chk("seq0", pc, 32'h0);
        idle(); chk("seq4", pc, 32'h4);
        idle(); chk("seq8", pc, 32'h8);
        chk("seq_empty", 32'(ras_empty), 32'd1);

        idle(); idle();
        chk("at10", pc, 32'h10);
        drive(1, 0, 1, 32'h100, 0, 32'h0, 0);
        chk("call_pc", pc, 32'h100);
        chk("call_cnt", 32'(ras_cnt), 32'd1);
        idle(); chk("at104", pc, 32'h104);
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("ret_pc", pc, 32'h14);
        chk("ret_cnt", 32'(ras_cnt), 32'd0);

        for (int i = 0; i < 9; i++) drive(1, 0, 1, 32'h1000 * (i + 1), 0, 32'h0, 0);
        chk("nest_pc", pc, 32'h9000);
        chk("nest_full", 32'(ras_full), 32'd1);
        chk("nest_cnt", 32'(ras_cnt), 32'd8);
        chk("nest_ovf", 32'(ras_ovf), 32'(ERR));
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
            chk("unwind_pc", pc, 32'h1000 * (8 - k) + 32'h4);
        end
        chk("unwind_empty", 32'(ras_empty), 32'd1);

        drive(0, 0, 1, 32'h20, 0, 32'h0, 0);
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("popempty_pc", pc, ERR ? 32'h20 : 32'h24);
        chk("popempty_cnt", 32'(ras_cnt), 32'd0);
        chk("popempty_unf", 32'(ras_unf), 32'(ERR));

        drive(0, 0, 1, 32'h40, 0, 32'h0, 0);
        drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFE, 0);
        chk("branch_back", pc, 32'h3C);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 32'h500, 1, 32'h7, 1);
            chk("halt_pc", pc, 32'h3C);
            chk("halt_cnt", 32'(ras_cnt), 32'd0);
        end

        drive(1, 0, 1, 32'h200, 0, 32'h0, 0);
        drive(1, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("swap_pc", pc, 32'h40);
        chk("swap_cnt", 32'(ras_cnt), 32'd1);
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("swap_ret", pc, 32'h204);

        drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("pre_rst_cnt", 32'(ras_cnt), 32'd1);
        push = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("async_pc", pc, RST_PC);
        chk("async_cnt", 32'(ras_cnt), 32'd0);
        idle();
        @(posedge clk);
        #1 reset = 1'b1;
        idle(); chk("rerun0", pc, 32'h0);
        idle(); chk("rerun4", pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
